// File: rtl/lockin_demod_accumulator.sv
// Lock-in demodulator: multiplies ADC samples by the DDS sine/cosine references and
// integrates X/Y over an integer number of reference periods framed by zero_cross.
module lockin_demod_accumulator #(
    parameter int B_in     = 14,
    parameter int B_ref    = 16,
    parameter int B_acc    = 48,
    parameter int B_cnt    = 32,
    parameter int B_ciclos = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [B_ciclos-1:0]     n_ciclos,
    input  logic [B_in-1:0]         data_in,
    input  logic                    data_in_valid,
    input  logic [B_ref-1:0]        ref_seno,
    input  logic [B_ref-1:0]        ref_coseno,
    input  logic                    ref_valid,
    input  logic                    zero_cross,
    output logic [B_acc-1:0]        x_out,
    output logic [B_acc-1:0]        y_out,
    output logic [B_cnt-1:0]        n_samples,
    output logic                    data_out_valid,
    output logic                    busy
);

    localparam int B_PROD = B_in + B_ref;
    localparam logic [B_cnt-1:0]    CNT_ONE = 1;
    localparam logic [B_ciclos-1:0] CIC_ONE = 1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ZC,
        ACCUM,
        FLUSH1,
        FLUSH2,
        DONE
    } state_t;

    state_t                     state_q, state_d;
    logic [B_ciclos-1:0]        ciclos_q, ciclos_d;
    logic [B_ciclos-1:0]        per_cnt_q, per_cnt_d;

    logic                       smp_vld_q, smp_vld_d;
    logic signed [B_in-1:0]     din_q, din_d;
    logic signed [B_ref-1:0]    sin_q, sin_d;
    logic signed [B_ref-1:0]    cos_q, cos_d;

    logic                       prod_vld_q, prod_vld_d;
    logic signed [B_PROD-1:0]   prod_x_q, prod_x_d;
    logic signed [B_PROD-1:0]   prod_y_q, prod_y_d;

    logic signed [B_acc-1:0]    acc_x_q, acc_x_d;
    logic signed [B_acc-1:0]    acc_y_q, acc_y_d;
    logic [B_cnt-1:0]           cnt_q, cnt_d;

    logic [B_acc-1:0]           x_out_q, x_out_d;
    logic [B_acc-1:0]           y_out_q, y_out_d;
    logic [B_cnt-1:0]           n_samples_q, n_samples_d;
    logic                       dov_q, dov_d;

    logic                       accept;
    logic                       clear;
    logic                       qual;

    assign qual = data_in_valid & ref_valid;

    // Control: framing of the integration window by zero_cross
    always_comb begin
        state_d     = state_q;
        ciclos_d    = ciclos_q;
        per_cnt_d   = per_cnt_q;
        x_out_d     = x_out_q;
        y_out_d     = y_out_q;
        n_samples_d = n_samples_q;
        dov_d       = 1'b0;
        accept      = 1'b0;
        clear       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = WAIT_ZC;
                    ciclos_d  = (n_ciclos == '0) ? CIC_ONE : n_ciclos;
                    per_cnt_d = '0;
                    clear     = 1'b1;
                end
            end
            WAIT_ZC: begin
                if (zero_cross) begin
                    state_d   = ACCUM;
                    per_cnt_d = CIC_ONE;
                    accept    = qual;
                end
            end
            ACCUM: begin
                if (zero_cross) begin
                    if (per_cnt_q < ciclos_q) begin
                        per_cnt_d = per_cnt_q + CIC_ONE;
                        accept    = qual;
                    end else begin
                        state_d = FLUSH1;
                    end
                end else begin
                    accept = qual;
                end
            end
            FLUSH1: state_d = FLUSH2;
            FLUSH2: state_d = DONE;
            DONE: begin
                state_d     = IDLE;
                x_out_d     = acc_x_q;
                y_out_d     = acc_y_q;
                n_samples_d = cnt_q;
                dov_d       = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: sample register -> full-precision products -> wrapping accumulators
    always_comb begin
        smp_vld_d  = accept;
        din_d      = din_q;
        sin_d      = sin_q;
        cos_d      = cos_q;
        if (accept) begin
            din_d = data_in;
            sin_d = ref_seno;
            cos_d = ref_coseno;
        end

        prod_vld_d = smp_vld_q;
        prod_x_d   = B_PROD'(din_q) * B_PROD'(sin_q);
        prod_y_d   = B_PROD'(din_q) * B_PROD'(cos_q);

        acc_x_d    = acc_x_q;
        acc_y_d    = acc_y_q;
        cnt_d      = cnt_q;
        if (prod_vld_q) begin
            acc_x_d = acc_x_q + B_acc'(prod_x_q);
            acc_y_d = acc_y_q + B_acc'(prod_y_q);
            if (cnt_q != '1)
                cnt_d = cnt_q + CNT_ONE;
        end

        if (clear) begin
            smp_vld_d  = 1'b0;
            prod_vld_d = 1'b0;
            acc_x_d    = '0;
            acc_y_d    = '0;
            cnt_d      = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ciclos_q    <= '0;
            per_cnt_q   <= '0;
            smp_vld_q   <= 1'b0;
            din_q       <= '0;
            sin_q       <= '0;
            cos_q       <= '0;
            prod_vld_q  <= 1'b0;
            prod_x_q    <= '0;
            prod_y_q    <= '0;
            acc_x_q     <= '0;
            acc_y_q     <= '0;
            cnt_q       <= '0;
            x_out_q     <= '0;
            y_out_q     <= '0;
            n_samples_q <= '0;
            dov_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ciclos_q    <= ciclos_d;
            per_cnt_q   <= per_cnt_d;
            smp_vld_q   <= smp_vld_d;
            din_q       <= din_d;
            sin_q       <= sin_d;
            cos_q       <= cos_d;
            prod_vld_q  <= prod_vld_d;
            prod_x_q    <= prod_x_d;
            prod_y_q    <= prod_y_d;
            acc_x_q     <= acc_x_d;
            acc_y_q     <= acc_y_d;
            cnt_q       <= cnt_d;
            x_out_q     <= x_out_d;
            y_out_q     <= y_out_d;
            n_samples_q <= n_samples_d;
            dov_q       <= dov_d;
        end
    end

    assign x_out          = x_out_q;
    assign y_out          = y_out_q;
    assign n_samples      = n_samples_q;
    assign data_out_valid = dov_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_lockin_demod_accumulator.sv
// Bench for lockin_demod_accumulator: table vectors, corner sequences and random runs
// checked against a window-summing reference model.
module tb_lockin_demod_accumulator;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] n_ciclos;
    logic [13:0] data_in;
    logic        data_in_valid;
    logic [15:0] ref_seno;
    logic [15:0] ref_coseno;
    logic        ref_valid;
    logic        zero_cross;
    logic [47:0] x_out;
    logic [47:0] y_out;
    logic [31:0] n_samples;
    logic        data_out_valid;
    logic        busy;

    always #5 clk = ~clk;

    lockin_demod_accumulator dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .n_ciclos       (n_ciclos),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .ref_seno       (ref_seno),
        .ref_coseno     (ref_coseno),
        .ref_valid      (ref_valid),
        .zero_cross     (zero_cross),
        .x_out          (x_out),
        .y_out          (y_out),
        .n_samples      (n_samples),
        .data_out_valid (data_out_valid),
        .busy           (busy)
    );

    typedef struct {
        logic        start;
        logic        zc;
        logic        dv;
        logic        rv;
        logic [13:0] din;
        logic [15:0] sn;
        logic [15:0] cs;
    } cyc_t;

    typedef struct {
        string  name;
        int     nc;
        int     period;
        bit     dv_alt;
        int     din;
        int     sn;
        int     cs;
        longint ex;
        longint ey;
        longint en;
    } vec_t;

    cyc_t stim[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input cyc_t c, input int nc);
        start         = c.start;
        zero_cross    = c.zc;
        data_in_valid = c.dv;
        ref_valid     = c.rv;
        data_in       = c.din;
        ref_seno      = c.sn;
        ref_coseno    = c.cs;
        n_ciclos      = nc[15:0];
    endtask

    function automatic cyc_t idle_cyc();
        cyc_t c;
        c.start = 1'b0; c.zc = 1'b0; c.dv = 1'b0; c.rv = 1'b0;
        c.din = '0; c.sn = '0; c.cs = '0;
        return c;
    endfunction

    // start at cycle 0, zero_cross every `period` cycles, last entry is the terminating edge
    task automatic build(input int nc, input int period, input bit dv_alt,
                         input int din, input int sn, input int cs);
        int   neff;
        int   len;
        cyc_t c;
        stim.delete();
        neff = (nc == 0) ? 1 : nc;
        len  = period * (neff + 1) + 1;
        for (int i = 0; i < len; i++) begin
            c.start = (i == 0);
            c.zc    = (i > 0) && (i % period == 0);
            c.dv    = dv_alt ? (i % 2 == 0) : 1'b1;
            c.rv    = 1'b1;
            c.din   = din[13:0];
            c.sn    = sn[15:0];
            c.cs    = cs[15:0];
            stim.push_back(c);
        end
    endtask

    // Sum qualified products from the first zero_cross after start up to (excluding)
    // the n-th zero_cross after it; result appears 3 edges after that terminating edge.
    task automatic model(input int nc, output longint ex, output longint ey,
                         output longint en, output int eedge);
        int s, z0, term, k, neff;
        longint sx, sy;
        logic signed [47:0] wx, wy;
        s = -1; z0 = -1; term = -1; k = 0;
        sx = 0; sy = 0; en = 0;
        neff = (nc == 0) ? 1 : nc;
        foreach (stim[i]) if (s < 0 && stim[i].start) s = i;
        for (int i = s + 1; i < stim.size() && s >= 0; i++)
            if (z0 < 0 && stim[i].zc) z0 = i;
        for (int i = z0 + 1; i < stim.size() && z0 >= 0; i++) begin
            if (term < 0 && stim[i].zc) begin
                k++;
                if (k == neff) term = i;
            end
        end
        if (term >= 0) begin
            for (int i = z0; i < term; i++) begin
                if (stim[i].dv && stim[i].rv) begin
                    sx += longint'($signed(stim[i].din)) * longint'($signed(stim[i].sn));
                    sy += longint'($signed(stim[i].din)) * longint'($signed(stim[i].cs));
                    en++;
                end
            end
        end
        wx = sx[47:0];
        wy = sy[47:0];
        ex = wx;
        ey = wy;
        eedge = (term >= 0) ? term + 3 : -1;
    endtask

    task automatic run(input string name, input int nc,
                       output longint gx, output longint gy, output longint gn);
        longint ex, ey, en;
        int     eedge, gedge, pulses, busy_at_done, total;
        model(nc, ex, ey, en, eedge);
        gedge = -1; pulses = 0; busy_at_done = 1;
        gx = 0; gy = 0; gn = 0;
        total = stim.size() + 12;
        for (int i = 0; i < total; i++) begin
            @(negedge clk);
            if (i < stim.size()) drive(stim[i], nc);
            else drive(idle_cyc(), nc);
            @(posedge clk);
            #1;
            if (i == 0) chk({name, "/busy_after_start"}, longint'(busy), 1);
            if (data_out_valid) begin
                pulses++;
                gedge = i;
                gx = $signed(x_out);
                gy = $signed(y_out);
                gn = n_samples;
                busy_at_done = busy;
            end
        end
        chk({name, "/dov_pulses"}, pulses, 1);
        chk({name, "/dov_edge"}, gedge, eedge);
        chk({name, "/x_out"}, gx, ex);
        chk({name, "/y_out"}, gy, ey);
        chk({name, "/n_samples"}, gn, en);
        chk({name, "/busy_at_done"}, busy_at_done, 0);
        chk({name, "/x_hold"}, $signed(x_out), ex);
    endtask

    vec_t vecs[5];

    initial begin
        longint gx, gy, gn;
        int     pulses;
        cyc_t   c;

        vecs[0] = '{"base",    1, 10, 1'b0, 100,   1000,   -500,  64'd1000000,   -64'sd500000,     64'd10};
        vecs[1] = '{"n3",      3, 10, 1'b0, 100,   1000,   -500,  64'd3000000,   -64'sd1500000,    64'd30};
        vecs[2] = '{"n0",      0, 10, 1'b0, 100,   1000,   -500,  64'd1000000,   -64'sd500000,     64'd10};
        vecs[3] = '{"dv_alt",  1, 10, 1'b1, 100,   1000,   -500,  64'd500000,    -64'sd250000,     64'd5};
        vecs[4] = '{"extreme", 1, 4,  1'b0, -8192, -32768, 32767, 64'd1073741824, -64'sd1073709056, 64'd4};

        reset_n = 1'b0;
        drive(idle_cyc(), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset/x_out", $signed(x_out), 0);
        chk("reset/y_out", $signed(y_out), 0);
        chk("reset/n_samples", n_samples, 0);
        chk("reset/dov", data_out_valid, 0);
        chk("reset/busy", busy, 0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[v]) begin
            build(vecs[v].nc, vecs[v].period, vecs[v].dv_alt, vecs[v].din, vecs[v].sn, vecs[v].cs);
            run(vecs[v].name, vecs[v].nc, gx, gy, gn);
            chk({vecs[v].name, "/x_const"}, gx, vecs[v].ex);
            chk({vecs[v].name, "/y_const"}, gy, vecs[v].ey);
            chk({vecs[v].name, "/n_const"}, gn, vecs[v].en);
        end

        // start while accumulating must be ignored
        build(1, 10, 1'b0, 100, 1000, -500);
        stim[13].start = 1'b1;
        run("start_in_accum", 1, gx, gy, gn);
        chk("start_in_accum/x_const", gx, 1000000);
        chk("start_in_accum/n_const", gn, 10);

        // zero_cross together with start does not open the window
        build(1, 10, 1'b0, 100, 1000, -500);
        stim[0].zc = 1'b1;
        run("start_with_zc", 1, gx, gy, gn);
        chk("start_with_zc/x_const", gx, 1000000);
        chk("start_with_zc/n_const", gn, 10);

        // reset mid-ACCUM discards the measurement
        build(1, 10, 1'b0, 100, 1000, -500);
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(stim[i], 1);
            @(posedge clk);
            #1;
            if (data_out_valid) pulses++;
        end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midreset/x_out", $signed(x_out), 0);
        chk("midreset/y_out", $signed(y_out), 0);
        chk("midreset/n_samples", n_samples, 0);
        chk("midreset/busy", busy, 0);
        chk("midreset/dov", data_out_valid, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 17; i < 45; i++) begin
            @(negedge clk);
            if (i < stim.size()) begin
                c = stim[i];
                drive(c, 1);
            end else begin
                drive(idle_cyc(), 1);
            end
            @(posedge clk);
            #1;
            if (data_out_valid) pulses++;
        end
        chk("midreset/no_dov", pulses, 0);
        build(1, 10, 1'b0, 100, 1000, -500);
        run("after_reset", 1, gx, gy, gn);
        chk("after_reset/x_const", gx, 1000000);
        chk("after_reset/y_const", gy, -500000);

        // randomized windows, qualifiers and data
        for (int r = 0; r < 8; r++) begin
            int nc, period;
            nc     = $urandom_range(0, 3);
            period = $urandom_range(2, 12);
            build(nc, period, 1'b0, 0, 0, 0);
            foreach (stim[i]) begin
                stim[i].dv  = ($urandom_range(0, 3) != 0);
                stim[i].rv  = ($urandom_range(0, 3) != 0);
                stim[i].din = 14'($urandom);
                stim[i].sn  = 16'($urandom);
                stim[i].cs  = 16'($urandom);
            end
            run($sformatf("rand%0d", r), nc, gx, gy, gn);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lockin_demod_accumulator.md
Name: lockin_demod_accumulator

Overview:
- Lock-in demodulation stage directly downstream of the DDS reference generator.
- Multiplies each signed ADC sample by the DDS AC-coupled sine and cosine references.
- Accumulates the products over an integer number of reference periods, framed by the DDS zero_cross pulse.
- Presents the in-phase (X) and quadrature (Y) sums plus a sample count to the averaging/readout logic with a one-cycle valid strobe.

Parameters:
- B_in, 14, width of the signed input sample
- B_ref, 16, width of the signed sine/cosine references (matches DDS B_out)
- B_acc, 48, width of the signed X/Y accumulators
- B_cnt, 32, width of the sample counter
- B_ciclos, 16, width of the period-count input

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a measurement
- n_ciclos  in  B_ciclos  number of reference periods to integrate; sampled on accepted start
- data_in  in  B_in  signed ADC sample
- data_in_valid  in  1  data_in qualifier
- ref_seno  in  B_ref  signed sine reference
- ref_coseno  in  B_ref  signed cosine reference
- ref_valid  in  1  reference qualifier
- zero_cross  in  1  one-cycle pulse marking the start of a reference period
- x_out  out  B_acc  signed sum of data_in*ref_seno
- y_out  out  B_acc  signed sum of data_in*ref_coseno
- n_samples  out  B_cnt  number of products accumulated
- data_out_valid  out  1  one-cycle result strobe
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (asynchronous, reset_n=0): state IDLE; x_out, y_out, n_samples, data_out_valid, busy, the internal accumulators, product registers and period counter all 0. Reset asserted mid-measurement discards the measurement; no data_out_valid is produced.
- States: IDLE, WAIT_ZC, ACCUM, FLUSH1, FLUSH2, DONE.
- IDLE: start=1 -> WAIT_ZC. Latch n_ciclos (value 0 is treated as 1). Clear accumulators and counters. zero_cross in the same cycle as start is ignored.
- start while busy: ignored.
- WAIT_ZC: on zero_cross=1 -> ACCUM. The sample of that same cycle is the first accumulated sample (subject to qualification). Set period counter to 1.
- Sample qualification: a sample is accepted when data_in_valid=1, ref_valid=1, and it is the zero_cross entry cycle in WAIT_ZC or any ACCUM cycle except the terminating one.
- ACCUM:
  - zero_cross with period counter < n_ciclos: increment period counter; the sample of that cycle is accepted.
  - zero_cross with period counter = n_ciclos: terminating edge. The sample of that cycle is NOT accepted; go to FLUSH1.
- Pipeline:
  - Accepted sample at edge t -> registered products (B_in+B_ref signed, full precision, no truncation) at edge t+1.
  - Sign-extended add into X/Y at edge t+2.
  - n_samples counter increments at edge t+2 alongside the add.
- FLUSH1 -> FLUSH2 -> DONE unconditionally, draining the two pipeline stages.
- DONE: register accumulators to x_out/y_out/n_samples and pulse data_out_valid for exactly one cycle, i.e., 3 edges after the edge that sampled the terminating zero_cross. Then go to IDLE.
- x_out/y_out/n_samples hold until the next DONE or reset.
- Arithmetic:
  - Accumulators wrap in two's complement; no saturation.
  - n_samples saturates at all-ones.
- busy: asserted from the edge following an accepted start, deasserted in the same cycle data_out_valid goes high.

Test Plan:
- All valids=1, data_in=100, ref_seno=1000, ref_coseno=-500, zero_cross every 10 cycles, n_ciclos=1 -> x_out=1000000, y_out=-500000, n_samples=10; data_out_valid high for one cycle, 3 edges after the 2nd zero_cross.
- Same stimulus, n_ciclos=3 -> x_out=3000000, y_out=-1500000, n_samples=30. Repeat with n_ciclos=0 -> results identical to n_ciclos=1.
- data_in_valid low on alternate cycles (ref_valid high), n_ciclos=1, period 10 -> n_samples=5, x_out=500000.
- Extremes: data_in=-8192, ref_seno=-32768, ref_coseno=32767, 1 period of 4 samples -> x_out=1073741824, y_out=-1073709056.
- start pulsed in ACCUM -> ignored, results unchanged. start coincident with zero_cross -> accumulation begins at the next zero_cross.
- reset_n dropped for 1 cycle mid-ACCUM -> all outputs 0 immediately, busy=0, no data_out_valid. A subsequent start yields correct fresh results.
